// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared types and constants for the pipeline hazard controller.
//            Includes the controller state encoding, default widths, the NOP
//            word the datapath loads into a flushed pipeline register, and
//            the bundle of write enables and flushes the controller drives.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Default register-specifier width and stall-counter width.
  localparam int REG_W = 4;
  localparam int CNT_W = 16;

  // The datapath writes this word into a pipeline register when its flush is
  // asserted. It decodes to "no register write, no memory access".
  localparam logic [31:0] c_nop_instr = 32'h0000_0000;

  // RUN   : normal issue.
  // DWAIT : a data access in MEM is still outstanding, so the whole pipe is frozen.
  // HALT  : the HLT instruction reached WB; the core stays stopped until reset.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // Every enable and flush the controller produces in a single cycle.
  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

  // Whole pipe frozen: no register updates and no flushes.
  localparam ctrl_t c_ctrl_freeze  = ctrl_t'(7'b00000_00);
  // Every stage advances and no flushes are applied.
  localparam ctrl_t c_ctrl_advance = ctrl_t'(7'b11111_00);

  // Front-end bubble. PC and IF/ID hold, and ID/EX takes a NOP. The back end
  // keeps draining. The ID/EX write enable stays high, so the NOP is
  // actually loaded.
  function automatic ctrl_t ctrl_bubble();
    ctrl_t c;
    c             = c_ctrl_advance;
    c.pc_we       = 1'b0;
    c.if_id_we    = 1'b0;
    c.id_ex_flush = 1'b1;
    return c;
  endfunction

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Purpose  : Combinational load-use hazard detector. It flags an instruction
//            in ID that needs the result of a load still in EX, because that
//            value cannot be forwarded in time.
// Ports    : i_id_rs, i_id_rt     - source specifiers of the ID instruction
//            i_id_uses_rt         - ID instruction reads rt
//            i_id_rt_is_sdata     - rt is only store data (MEM-MEM forwardable)
//            i_ex_memread         - EX instruction is a load
//            i_ex_rd              - EX destination specifier
//            o_lu_hz              - hazard: ID must wait one cycle
// Revision : 1.0 - initial release
// ============================================================================
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = pipe_ctrl_pkg::REG_W
) (
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic             i_id_rt_is_sdata,
  input  logic             i_ex_memread,
  input  logic [REG_W-1:0] i_ex_rd,
  output logic             o_lu_hz
);

  logic w_rd_nonzero;
  logic w_rs_match;
  logic w_rt_match;

  // Register 0 is hard-wired, so a load that targets it creates no dependence.
  assign w_rd_nonzero = (i_ex_rd != '0);
  assign w_rs_match   = (i_ex_rd == i_id_rs);

  // An rt that is used only as store data is picked up later by the
  // MEM-to-MEM forward path. It does not need a stall.
  assign w_rt_match   = i_id_uses_rt & ~i_id_rt_is_sdata & (i_ex_rd == i_id_rt);

  assign o_lu_hz      = i_ex_memread & w_rd_nonzero & (w_rs_match | w_rt_match);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Sequences a 5-stage pipeline around the forwarding unit. It
//            stalls on load-use hazards and freezes on multi-cycle imem/dmem
//            accesses. It flushes IF/ID and ID/EX on a taken branch and holds
//            the core on HALT. It drives every pipeline-register write enable
//            and flush, and it counts the cycles in which the PC is held.
// Ports    : clk, rst_n            - clock, async active-low reset
//            i_id_rs, i_id_rt      - ID source specifiers
//            i_id_uses_rt          - ID instruction reads rt
//            i_id_rt_is_sdata      - ID rt is store data only
//            i_ex_memread, i_ex_rd - EX load flag and destination
//            i_ex_br_taken         - branch in EX resolved taken
//            i_imem_busy           - fetch not complete this cycle
//            i_dmem_busy           - data access not complete this cycle
//            i_wb_halt             - HLT instruction in WB
//            o_*_we                - pipeline register write enables
//            o_if_id_flush, o_id_ex_flush - load NOP on next edge
//            o_redirect_sel        - PC mux takes the held branch target
//            o_halted              - core stopped (sticky until reset)
//            o_stall_cnt           - saturating count of cycles with pc_we=0
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = pipe_ctrl_pkg::REG_W,
  parameter int CNT_W = pipe_ctrl_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic             i_id_rt_is_sdata,
  input  logic             i_ex_memread,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_br_taken,
  input  logic             i_imem_busy,
  input  logic             i_dmem_busy,
  input  logic             i_wb_halt,
  output logic             o_pc_we,
  output logic             o_if_id_we,
  output logic             o_id_ex_we,
  output logic             o_ex_mem_we,
  output logic             o_mem_wb_we,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_redirect_sel,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_redir_pend;
  logic             w_redir_pend_nxt;
  logic             w_redir_set;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_cnt_inc;
  logic             w_lu_hz;
  ctrl_t            w_ctrl;

  // --------------------------------------------------------------------------
  // Load-use hazard detection
  // --------------------------------------------------------------------------
  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use_detect (
    .i_id_rs          (i_id_rs),
    .i_id_rt          (i_id_rt),
    .i_id_uses_rt     (i_id_uses_rt),
    .i_id_rt_is_sdata (i_id_rt_is_sdata),
    .i_ex_memread     (i_ex_memread),
    .i_ex_rd          (i_ex_rd),
    .o_lu_hz          (w_lu_hz)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and pipeline control
  // --------------------------------------------------------------------------
  // DWAIT uses the same decision tree as RUN. The HALT and dmem checks come
  // first, so DWAIT keeps the pipe frozen while dmem_busy is high. On the
  // first cycle with dmem_busy low, the cycle is evaluated as a normal RUN
  // cycle, so no issue slot is lost when the access completes.
  always_comb begin
    w_ctrl      = c_ctrl_freeze;
    w_state_nxt = r_state;
    w_redir_set = 1'b0;

    case (r_state)
      ST_RUN, ST_DWAIT: begin
        if (i_wb_halt) begin
          w_state_nxt = ST_HALT;
        end else if (i_dmem_busy) begin
          // A pending branch or bubble is not applied while frozen. The
          // branch is still in EX when the pipe resumes and is handled then.
          w_state_nxt = ST_DWAIT;
        end else begin
          w_state_nxt = ST_RUN;
          w_ctrl      = c_ctrl_advance;
          if (i_ex_br_taken) begin
            w_ctrl.if_id_flush = 1'b1;
            w_ctrl.id_ex_flush = 1'b1;
            // The fetch is still in flight, so the PC cannot take the target
            // now. The target is held outside the block, and the redirect is
            // replayed when the PC is next written.
            if (i_imem_busy) begin
              w_ctrl.pc_we = 1'b0;
              w_redir_set  = 1'b1;
            end
          end else if (w_lu_hz || i_imem_busy) begin
            w_ctrl = ctrl_bubble();
          end
        end
      end

      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end

      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Deferred branch redirect
  // --------------------------------------------------------------------------
  // The pending flag stays set until the first cycle in which the PC is
  // actually written. In that cycle the held target is still selected.
  assign w_redir_pend_nxt = w_redir_set | (r_redir_pend & ~w_ctrl.pc_we);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redir_pend <= 1'b0;
    end else begin
      r_redir_pend <= w_redir_pend_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating stall-cycle counter (frozen once halted)
  // --------------------------------------------------------------------------
  assign w_cnt_inc = (r_state != ST_HALT) & ~w_ctrl.pc_we & (r_stall_cnt != '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_stall_cnt <= r_stall_cnt + c_cnt_one;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The control outputs are combinational from the state and the inputs.
  // They are gated with rst_n so that every output reads 0 while reset is
  // held, whatever the inputs are.
  assign o_pc_we        = rst_n & w_ctrl.pc_we;
  assign o_if_id_we     = rst_n & w_ctrl.if_id_we;
  assign o_id_ex_we     = rst_n & w_ctrl.id_ex_we;
  assign o_ex_mem_we    = rst_n & w_ctrl.ex_mem_we;
  assign o_mem_wb_we    = rst_n & w_ctrl.mem_wb_we;
  assign o_if_id_flush  = rst_n & w_ctrl.if_id_flush;
  assign o_id_ex_flush  = rst_n & w_ctrl.id_ex_flush;
  assign o_redirect_sel = rst_n & r_redir_pend;
  assign o_halted       = rst_n & (r_state == ST_HALT);
  assign o_stall_cnt    = r_stall_cnt;

endmodule : pipeline_hazard_ctrl
`default_nettype wire
